// File: rtl/datapath_mc.sv
// Register-file datapath: single-cycle ALU/load ops and iterative shift/multiply ops.
// Defining DATAPATH_MUL_EN builds the iterative FS=1111 multiplier; without it FS=1111 is a NOP.
module datapath_mc #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned SEL_W = 2,
    localparam int unsigned NREGS = 2**SEL_W,
    localparam int unsigned CW_W  = 3*SEL_W + 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CW_W-1:0]        cw,
    input  logic                   cw_valid,
    output logic                   cw_ready,
    input  logic [WIDTH-1:0]       ConstantIn,
    input  logic [WIDTH-1:0]       data_in,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             flags
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef DATAPATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] rf [NREGS];

    // Control word fields {DA, AA, BA, MB, FS, MD, RW}
    logic [SEL_W-1:0] f_da, f_aa, f_ba;
    logic             f_mb, f_md, f_rw;
    logic [3:0]       f_fs;

    assign f_rw = cw[0];
    assign f_md = cw[1];
    assign f_fs = cw[5:2];
    assign f_mb = cw[6];
    assign f_ba = cw[7 +: SEL_W];
    assign f_aa = cw[7 + SEL_W +: SEL_W];
    assign f_da = cw[7 + 2*SEL_W +: SEL_W];

    logic             accept;
    logic             is_shift_fs, is_mul_fs, is_nop, is_multi;
    logic [WIDTH-1:0] op_a, op_b;

    assign cw_ready    = ~rst & (state == S_IDLE);
    assign accept      = cw_valid & cw_ready;
    assign op_a        = rf[f_aa];
    assign op_b        = f_mb ? ConstantIn : rf[f_ba];
    assign is_shift_fs = (f_fs == 4'b1101) | (f_fs == 4'b1110);
    assign is_mul_fs   = MUL_EN & (f_fs == 4'b1111);
    assign is_nop      = ~MUL_EN & (f_fs == 4'b1111);
    assign is_multi    = is_shift_fs | is_mul_fs;

    // Adder operand selection for the arithmetic group
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (f_fs)
            4'b0001: add_cin = 1'b1;
            4'b0010: add_b = op_b;
            4'b0011: begin add_b = op_b;  add_cin = 1'b1; end
            4'b0100: add_b = ~op_b;
            4'b0101: begin add_b = ~op_b; add_cin = 1'b1; end
            4'b0110: add_b = '1;
            default: ;
        endcase
    end

    assign sum   = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_v = (op_a[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);

    // Single-cycle result and flag sources
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        alu_res = op_a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (f_fs)
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_v;
            end
            4'b1000: alu_res = op_a & op_b;
            4'b1001: alu_res = op_a | op_b;
            4'b1010: alu_res = op_a ^ op_b;
            4'b1011: alu_res = ~op_a;
            4'b1100: alu_res = op_b;
            default: alu_res = op_a;
        endcase
    end

    logic             sc_write, sc_flag_we;
    logic [WIDTH-1:0] sc_wdata;

    assign sc_write   = accept & f_rw & (f_md | (~is_multi & ~is_nop));
    assign sc_flag_we = accept & ~f_md & ~is_multi & ~is_nop;
    assign sc_wdata   = f_md ? data_in : alu_res;

    // Shift length: min(B, WIDTH), never less than one busy cycle
    logic [CNT_W-1:0] sh_len;

    always_comb begin
        if (32'(op_b) >= WIDTH) begin
            sh_len = CNT_W'(WIDTH);
        end else if (op_b == '0) begin
            sh_len = CNT_W'(1);
        end else begin
            sh_len = CNT_W'(op_b);
        end
    end

    // Latched multi-cycle context
    logic [WIDTH-1:0] acc;
    logic [SEL_W-1:0] lat_da;
    logic             lat_rw, shr, sh_en;
    logic [CNT_W-1:0] cnt;
    logic             finish;

    assign finish = (state != S_IDLE) & (cnt == CNT_W'(1));

    logic [WIDTH-1:0] sh_nxt;
    logic             sh_c;

    always_comb begin
        sh_nxt = acc;
        sh_c   = 1'b0;
        if (sh_en) begin
            if (shr) begin
                sh_nxt = {1'b0, acc[WIDTH-1:1]};
                sh_c   = acc[0];
            end else begin
                sh_nxt = {acc[WIDTH-2:0], 1'b0};
                sh_c   = acc[WIDTH-1];
            end
        end
    end

`ifdef DATAPATH_MUL_EN
    logic [2*WIDTH-1:0] prod, mcand, prod_nxt;
    logic [WIDTH-1:0]   mplier;

    assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
`endif

    logic [WIDTH-1:0] mc_res;
    logic             mc_c;

    always_comb begin
        mc_res = sh_nxt;
        mc_c   = sh_c;
`ifdef DATAPATH_MUL_EN
        if (state == S_MUL) begin
            mc_res = prod_nxt[WIDTH-1:0];
            mc_c   = |prod_nxt[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept & ~f_md & is_multi) begin
                    state_nxt = is_mul_fs ? S_MUL : S_SHIFT;
                end
            end
            S_SHIFT, S_MUL: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Register file, flags, status and iterative operand state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
            flags  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            lat_da <= '0;
            lat_rw <= 1'b0;
            shr    <= 1'b0;
            sh_en  <= 1'b0;
            cnt    <= '0;
`ifdef DATAPATH_MUL_EN
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
`endif
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != S_IDLE);
            if (accept & ~f_md & is_multi) begin
                acc    <= op_a;
                lat_da <= f_da;
                lat_rw <= f_rw;
                shr    <= (f_fs == 4'b1101);
                sh_en  <= (op_b != '0);
                cnt    <= is_mul_fs ? CNT_W'(WIDTH) : sh_len;
`ifdef DATAPATH_MUL_EN
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, op_a};
                mplier <= op_b;
`endif
            end else if (state != S_IDLE) begin
                acc <= sh_nxt;
                cnt <= cnt - CNT_W'(1);
`ifdef DATAPATH_MUL_EN
                prod   <= prod_nxt;
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
`endif
            end

            if (finish) begin
                if (lat_rw) begin
                    rf[lat_da] <= mc_res;
                end
                flags <= {mc_res == '0, mc_res[WIDTH-1], mc_c, 1'b0};
                done  <= 1'b1;
            end else if (sc_write) begin
                rf[f_da] <= sc_wdata;
            end

            if (sc_flag_we) begin
                flags <= {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
            end
        end
    end

    for (genvar g = 0; g < int'(NREGS); g++) begin : g_regs
        assign regs[g*WIDTH +: WIDTH] = rf[g];
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc at WIDTH=4, SEL_W=2; covers both DATAPATH_MUL_EN builds.
module tb_datapath_mc;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CW_W  = 3*SEL_W + 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW_W-1:0]  cw;
    logic             cw_valid;
    logic             cw_ready;
    logic [WIDTH-1:0] ConstantIn;
    logic [WIDTH-1:0] data_in;
    logic [15:0]      regs;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    int n_vec = 0;
    int n_err = 0;
    int n;
    int rdy_bad;

    datapath_mc #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cw         (cw),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .ConstantIn (ConstantIn),
        .data_in    (data_in),
        .regs       (regs),
        .busy       (busy),
        .done       (done),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    function automatic logic [CW_W-1:0] mk(input logic [1:0] da, input logic [1:0] aa,
                                           input logic [1:0] ba, input logic mb,
                                           input logic [3:0] fs, input logic md, input logic rw);
        return {da, aa, ba, mb, fs, md, rw};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cw for exactly one accepting edge
    task automatic issue(input logic [CW_W-1:0] w);
        cw       = w;
        cw_valid = 1'b1;
        step();
        cw_valid = 1'b0;
    endtask

    // Count busy cycles after acceptance, bounded
    task automatic wait_busy(output int len, output int bad);
        len = 0;
        bad = 0;
        while (busy === 1'b1 && len < 20) begin
            if (cw_ready !== 1'b0) bad++;
            len++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; cw = '0; cw_valid = 1'b0; ConstantIn = '0; data_in = '0;
        step();
        step();
        chk("rst_ready", 32'(cw_ready), 32'd0);
        chk("rst_regs", 32'(regs), 32'h0000);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cw_ready), 32'd1);

        // Loads
        data_in = 4'd4; issue(mk(2'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
        chk("load_r0", 32'(regs), 32'h0004);
        data_in = 4'd5; issue(mk(2'd1, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
        chk("load_r1", 32'(regs), 32'h0054);
        chk("load_flags", 32'(flags), 32'h0);

        // Back-to-back single-cycle ops
        cw_valid = 1'b1;
        cw = mk(2'd2, 2'd0, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1);
        step();
        chk("add_regs", 32'(regs), 32'h0954);
        chk("add_flags", 32'(flags), 32'b0101);
        chk("add_ready", 32'(cw_ready), 32'd1);
        cw = mk(2'd3, 2'd0, 2'd1, 1'b0, 4'b0101, 1'b0, 1'b1);
        step();
        chk("sub_regs", 32'(regs), 32'hF954);
        chk("sub_flags", 32'(flags), 32'b0100);
        cw = mk(2'd0, 2'd3, 2'd1, 1'b0, 4'b1010, 1'b0, 1'b1);
        step();
        chk("xor_regs", 32'(regs), 32'hF95A);
        chk("xor_flags", 32'(flags), 32'b0100);
        cw = mk(2'd1, 2'd1, 2'd0, 1'b0, 4'b0110, 1'b0, 1'b1);
        step();
        cw_valid = 1'b0;
        chk("dec_regs", 32'(regs), 32'hF94A);
        chk("dec_flags", 32'(flags), 32'b0010);

        // Shift left by constant 3: 4 -> 0
        ConstantIn = 4'd3; issue(mk(2'd2, 2'd1, 2'd0, 1'b1, 4'b1110, 1'b0, 1'b1));
        chk("shl3_busy0", 32'({busy, cw_ready}), 32'b10);
        wait_busy(n, rdy_bad);
        chk("shl3_len", 32'(n), 32'd3);
        chk("shl3_ready_low", 32'(rdy_bad), 32'd0);
        chk("shl3_done", 32'({done, cw_ready}), 32'b11);
        chk("shl3_regs", 32'(regs), 32'hF04A);
        chk("shl3_flags", 32'(flags), 32'b1000);
        step();
        chk("shl3_done_pulse", 32'(done), 32'd0);

        // Shift left by 7 clamps to 4 cycles
        ConstantIn = 4'd7; issue(mk(2'd3, 2'd1, 2'd0, 1'b1, 4'b1110, 1'b0, 1'b1));
        wait_busy(n, rdy_bad);
        chk("shl7_len", 32'(n), 32'd4);
        chk("shl7_regs", 32'(regs), 32'h004A);
        chk("shl7_flags", 32'(flags), 32'b1000);

        // Shift right by 0: one busy cycle, result A, C=0
        ConstantIn = 4'd0; issue(mk(2'd2, 2'd0, 2'd0, 1'b1, 4'b1101, 1'b0, 1'b1));
        wait_busy(n, rdy_bad);
        chk("shr0_len", 32'(n), 32'd1);
        chk("shr0_regs", 32'(regs), 32'h0A4A);
        chk("shr0_flags", 32'(flags), 32'b0100);

        // Shift right by 2: 1010 -> 0010, last bit out 1
        ConstantIn = 4'd2; issue(mk(2'd3, 2'd0, 2'd0, 1'b1, 4'b1101, 1'b0, 1'b1));
        wait_busy(n, rdy_bad);
        chk("shr2_len", 32'(n), 32'd2);
        chk("shr2_regs", 32'(regs), 32'h2A4A);
        chk("shr2_flags", 32'(flags), 32'b0010);

        data_in = 4'd5; issue(mk(2'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
        data_in = 4'd6; issue(mk(2'd1, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
        chk("load56_regs", 32'(regs), 32'h2A65);

`ifdef DATAPATH_MUL_EN
        // 5*6 = 0x1E: low E, upper nonzero; a held load is taken in the done cycle
        issue(mk(2'd2, 2'd0, 2'd1, 1'b0, 4'b1111, 1'b0, 1'b1));
        data_in  = 4'd7;
        cw       = mk(2'd3, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
        cw_valid = 1'b1;
        wait_busy(n, rdy_bad);
        chk("mul_len", 32'(n), 32'd4);
        chk("mul_ready_low", 32'(rdy_bad), 32'd0);
        chk("mul_done", 32'({done, cw_ready}), 32'b11);
        chk("mul_regs", 32'(regs), 32'h2E65);
        chk("mul_flags", 32'(flags), 32'b0110);
        step();
        cw_valid = 1'b0;
        chk("mul_held_cw", 32'(regs), 32'h7E65);
        chk("mul_done_pulse", 32'(done), 32'd0);

        // Reset in second busy cycle of a multiply
        issue(mk(2'd2, 2'd0, 2'd1, 1'b0, 4'b1111, 1'b0, 1'b1));
`else
        // FS=1111 is a NOP in this build
        issue(mk(2'd2, 2'd0, 2'd1, 1'b0, 4'b1111, 1'b0, 1'b1));
        chk("nop_regs", 32'(regs), 32'h2A65);
        chk("nop_flags", 32'(flags), 32'b0010);
        chk("nop_busy_ready", 32'({busy, cw_ready}), 32'b01);
        step();
        chk("nop_no_busy", 32'({busy, done}), 32'd0);

        // Reset in second busy cycle of a clamped shift
        ConstantIn = 4'd7; issue(mk(2'd2, 2'd0, 2'd0, 1'b1, 4'b1110, 1'b0, 1'b1));
`endif
        chk("abort_busy1", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("abort_regs", 32'(regs), 32'h0000);
        chk("abort_status", 32'({busy, done, cw_ready}), 32'd0);
        chk("abort_flags", 32'(flags), 32'h0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(cw_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_done", 32'({done, busy}), 32'd0);
        end
        chk("abort_regs_final", 32'(regs), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
